xor_parity_accum: RTL and testbench

- Streaming parity engine: XORs NUM_SRC source blocks of DEPTH beats each, beat-wise, into an on-chip accumulator, then streams the DEPTH-beat parity block out.
- Generalises the fixed 64-bit two-operand XOR to parametrised width, N sources and block depth, with valid/ready handshakes.
- Sits between the DMA read path and the DDR write path in the cl_dram_dma_with_cpu datapath.

---
 rtl/xor_parity_pkg.sv | 21 ++
 rtl/xor_parity_mem.sv | 32 +++
 rtl/xor_parity_accum.sv | 145 ++++++++++++++
 tb/tb_xor_parity_accum.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/xor_parity_pkg.sv
// Shared types and width helpers for the streaming XOR parity engine.
package xor_parity_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_e;

    typedef enum logic {
        WR_OVR = 1'b0,
        WR_XOR = 1'b1
    } wr_mode_e;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BEAT_CW = cnt_w(8);
    localparam int SRC_CW  = cnt_w(4);

endpackage

// File: rtl/xor_parity_mem.sv
// DEPTH x DATA_W accumulator array: one overwrite/xor write port,
// one combinational read port. Contents are intentionally not reset.
module xor_parity_mem
    import xor_parity_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  wr_mode_e          wr_mode,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            if (wr_mode == WR_XOR)
                mem[wr_addr] <= mem[wr_addr] ^ wr_data;
            else
                mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/xor_parity_accum.sv
// Streaming parity engine: XORs NUM_SRC blocks of DEPTH beats, then drains.
// Optional parity_zero output enabled by XOR_PARITY_ZERO_CHECK_EN.
module xor_parity_accum
    import xor_parity_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 8,
    parameter int NUM_SRC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              err_len,
    input  logic              clr_err
`ifdef XOR_PARITY_ZERO_CHECK_EN
    ,
    output logic              parity_zero
`endif
);

    localparam int B_CW = cnt_w(DEPTH);
    localparam int S_CW = cnt_w(NUM_SRC);
    localparam logic [B_CW-1:0] BEAT_MAX = B_CW'(DEPTH - 1);
    localparam logic [S_CW-1:0] SRC_MAX  = S_CW'(NUM_SRC - 1);

    state_e            state_q;
    state_e            state_d;
    logic [B_CW-1:0]   beat_cnt;
    logic [S_CW-1:0]   src_cnt;
    logic [B_CW-1:0]   rd_cnt;
    logic [DATA_W-1:0] rd_data;
    logic              s_fire;
    logic              m_fire;
    logic              beat_end;
    logic              src_end;
    logic              rd_end;
    wr_mode_e          wr_mode;

    assign s_fire   = s_valid && (state_q == ACCUM);
    assign m_fire   = m_ready && (state_q == DRAIN);
    assign beat_end = (beat_cnt == BEAT_MAX);
    assign src_end  = (src_cnt == SRC_MAX);
    assign rd_end   = (rd_cnt == BEAT_MAX);
    assign wr_mode  = (src_cnt == '0) ? WR_OVR : WR_XOR;

    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        m_valid = 1'b0;
        unique case (state_q)
            ACCUM: begin
                s_ready = 1'b1;
                if (s_valid && beat_end && src_end)
                    state_d = DRAIN;
            end
            DRAIN: begin
                m_valid = 1'b1;
                if (m_ready && rd_end)
                    state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ACCUM;
            beat_cnt <= '0;
            src_cnt  <= '0;
            rd_cnt   <= '0;
        end else begin
            state_q <= state_d;
            if (s_fire) begin
                beat_cnt <= beat_end ? '0 : beat_cnt + B_CW'(1);
                if (beat_end)
                    src_cnt <= src_end ? '0 : src_cnt + S_CW'(1);
            end
            if (m_fire)
                rd_cnt <= rd_end ? '0 : rd_cnt + B_CW'(1);
        end
    end

    // Misplaced s_last only flags; control follows beat_cnt alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_len <= 1'b0;
        else if (s_fire && (s_last != beat_end))
            err_len <= 1'b1;
        else if (clr_err)
            err_len <= 1'b0;
    end

    xor_parity_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (B_CW)
    ) u_mem (
        .clk     (clk),
        .we      (s_fire),
        .wr_addr (beat_cnt),
        .wr_data (s_data),
        .wr_mode (wr_mode),
        .rd_addr (rd_cnt),
        .rd_data (rd_data)
    );

    assign m_data = (state_q == DRAIN) ? rd_data : '0;
    assign m_last = (state_q == DRAIN) && rd_end;
    assign busy   = (state_q == DRAIN) || (src_cnt != '0) ||
                    (beat_cnt != '0);

`ifdef XOR_PARITY_ZERO_CHECK_EN
    logic nz_q;
    logic pz_q;

    // nz_q ORs drained beats; the final beat folds in combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nz_q <= 1'b0;
            pz_q <= 1'b0;
        end else if (s_fire) begin
            nz_q <= 1'b0;
            pz_q <= 1'b0;
        end else if (m_fire) begin
            if (rd_end) begin
                nz_q <= 1'b0;
                pz_q <= !(nz_q || (|rd_data));
            end else begin
                nz_q <= nz_q || (|rd_data);
            end
        end
    end

    assign parity_zero = m_last ? !(nz_q || (|rd_data)) : pz_q;
`endif

endmodule

// File: tb/tb_xor_parity_accum.sv
// Directed bench for xor_parity_accum (DATA_W=64, DEPTH=8, NUM_SRC=4).
module tb_xor_parity_accum;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic        m_last;
    logic        busy;
    logic        err_len;
    logic        clr_err;
`ifdef XOR_PARITY_ZERO_CHECK_EN
    logic        parity_zero;
`endif

    int passed;
    int total;
    logic [63:0] mdl [8];
    logic [63:0] ex  [8];
    int bi;
    int si;

    xor_parity_accum #(
        .DATA_W  (64),
        .DEPTH   (8),
        .NUM_SRC (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .busy        (busy),
        .err_len     (err_len),
        .clr_err     (clr_err)
`ifdef XOR_PARITY_ZERO_CHECK_EN
        ,
        .parity_zero (parity_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drives one beat at a negedge; it is accepted at the next posedge.
    task automatic send(input logic [63:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(negedge clk);
        if (si == 0) mdl[bi] = d;
        else         mdl[bi] = mdl[bi] ^ d;
        bi++;
        if (bi == 8) begin
            bi = 0;
            si = (si == 3) ? 0 : si + 1;
        end
    endtask

    task automatic group(input int mode, input bit gaps,
                         input int es, input int ei);
        logic [63:0] d;
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 8; i++) begin
                case (mode)
                    0:       d = 64'h1 << (8 * s + i);
                    1:       d = 64'hDEAD_BEEF_0000_0000 | 64'(i);
                    default: d = {$urandom, $urandom};
                endcase
                if (gaps) begin
                    s_valid = 1'b0;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                if (s == 3 && i == 7) begin
                    chk("pre_last_mvalid", m_valid, 0);
                    chk("pre_last_busy", busy, 1);
                end
                send(d, (i == 7) ^ (s == es && i == ei));
                if (s == es && i == ei) chk("err_set", err_len, 1);
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain(input int stall_at);
        logic all_zero;
        all_zero = 1'b1;
        for (int j = 0; j < 8; j++)
            if (ex[j] != 64'h0) all_zero = 1'b0;
        for (int j = 0; j < 8; j++) begin
            chk("drain_mvalid", m_valid, 1);
            chk("drain_data", m_data, ex[j]);
            chk("drain_last", m_last, 64'(j == 7));
            chk("drain_sready", s_ready, 0);
            chk("drain_busy", busy, 1);
`ifdef XOR_PARITY_ZERO_CHECK_EN
            if (j == 7) chk("parity_zero", parity_zero, all_zero);
`endif
            if (j == stall_at) begin
                m_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_mvalid", m_valid, 1);
                    chk("stall_data", m_data, ex[j]);
                    chk("stall_last", m_last, 64'(j == 7));
                    chk("stall_sready", s_ready, 0);
                end
                m_ready = 1'b1;
            end
            @(negedge clk);
        end
        chk("post_sready", s_ready, 1);
        chk("post_mvalid", m_valid, 0);
        chk("post_mdata", m_data, 0);
        chk("post_mlast", m_last, 0);
        chk("post_busy", busy, 0);
`ifdef XOR_PARITY_ZERO_CHECK_EN
        chk("pz_hold", parity_zero, all_zero);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sready"}, s_ready, 1);
        chk({tag, "_mvalid"}, m_valid, 0);
        chk({tag, "_mdata"}, m_data, 0);
        chk({tag, "_mlast"}, m_last, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        bi      = 0;
        si      = 0;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        clr_err = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        chk("reset_err", err_len, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Walking-one sources: parity beat i = 0x01010101 << i.
        group(0, 1'b0, -1, -1);
        for (int i = 0; i < 8; i++) ex[i] = 64'h0101_0101 << i;
        drain(-1);

        // Identical sources back to back: overwrite hides stale contents.
        group(1, 1'b0, -1, -1);
        for (int i = 0; i < 8; i++) ex[i] = 64'h0;
        drain(-1);

        // Input gaps and a 5-cycle output stall mid-drain.
        group(2, 1'b1, -1, -1);
        for (int i = 0; i < 8; i++) ex[i] = mdl[i];
        chk("no_err_yet", err_len, 0);
        drain(4);

        // Misplaced s_last on beat 3 of source 1.
        group(2, 1'b0, 1, 3);
        for (int i = 0; i < 8; i++) ex[i] = mdl[i];
        drain(-1);
        chk("err_sticky", err_len, 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("err_clr", err_len, 0);

        // Two random groups back to back.
        group(2, 1'b0, -1, -1);
        for (int i = 0; i < 8; i++) ex[i] = mdl[i];
        drain(-1);
        group(2, 1'b0, -1, -1);
        for (int i = 0; i < 8; i++) ex[i] = mdl[i];
        drain(7);

        // Reset after 13 accepted beats.
        for (int i = 0; i < 13; i++) send({$urandom, $urandom}, (i % 8) == 7);
        s_valid = 1'b0;
        chk("mid_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_ingest");
        @(negedge clk);
        rst_n = 1'b1;
        bi = 0;
        si = 0;
        @(negedge clk);
        group(2, 1'b0, -1, -1);
        for (int i = 0; i < 8; i++) ex[i] = mdl[i];
        drain(-1);

        // Reset while drain beat 3 is presented.
        group(2, 1'b0, -1, -1);
        for (int i = 0; i < 8; i++) ex[i] = mdl[i];
        repeat (3) @(negedge clk);
        chk("pre_rst_data", m_data, ex[3]);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_drain");
        @(negedge clk);
        rst_n = 1'b1;
        bi = 0;
        si = 0;
        @(negedge clk);
        group(2, 1'b1, -1, -1);
        for (int i = 0; i < 8; i++) ex[i] = mdl[i];
        drain(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
